// File: rtl/shift_sequencer_if.sv
// Start/result handshake bundle between the ALU op decode and the shift sequencer.
// The master drives the request; the slave (sequencer) drives result and status.
interface shift_sequencer_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) ();
    logic               ctrl_start;
    logic [1:0]         ctrl_op;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_operandA;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               data_exception;
    logic               busy;

    modport master (
        output ctrl_start, ctrl_op, ctrl_shiftamt, data_operandA,
        input  data_result, data_resultRDY, data_exception, busy
    );

    modport slave (
        input  ctrl_start, ctrl_op, ctrl_shiftamt, data_operandA,
        output data_result, data_resultRDY, data_exception, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA built from fixed shift-by-2 and shift-by-1 steps applied
// to a working register, one step per cycle.
module shift_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic             clock,
    input logic             reset,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRsv = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         step;
    logic [WIDTH-1:0]   work_shifted;

    // Step size is min(count, 2) so count can never underflow.
    always_comb begin
        step = (count_q >= SHAMT_W'(2)) ? 2'd2 : 2'd1;
        case (op_q)
            OpSrl:   work_shifted = work_q >> step;
            OpSra:   work_shifted = $signed(work_q) >>> step;
            default: work_shifted = work_q << step;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.ctrl_start) begin
                    work_d  = bus.data_operandA;
                    count_d = bus.ctrl_shiftamt;
                    op_d    = bus.ctrl_op;
                    if (bus.ctrl_shiftamt == '0) begin
                        state_d  = StDone;
                        result_d = bus.data_operandA;
                    end else begin
                        state_d = StShift;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                work_d  = work_shifted;
                count_d = count_q - SHAMT_W'(step);
                if (count_d == '0) begin
                    state_d  = StDone;
                    result_d = work_shifted;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= 2'b00;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = (state_q == StDone);
    assign bus.data_exception = (state_q == StDone) && (op_q == OpRsv);
    assign bus.busy           = (state_q == StShift);
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed cases plus random traffic against
// an arithmetic shift model with latency/busy timing derived from the shift amount.
module tb_shift_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;

    shift_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cyc = -100;
    int          acc_lat = 0;
    logic [31:0] last_res = '0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] ref_shift(logic [31:0] a, logic [1:0] op, int amt);
        logic signed [31:0] s;
        s = a;
        case (op)
            2'b01:   return a >> amt;
            2'b10:   return s >>> amt;
            default: return a << amt;
        endcase
    endfunction

    function automatic logic model_busy(int c);
        return (c > acc_cyc) && (c < acc_cyc + acc_lat);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: cycle %0d got %h want %h", name, cyc, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, drivers act at falling edge + 1.
    always @(negedge clock) begin
        exp_t e;
        check("busy", {31'b0, bus.busy}, {31'b0, model_busy(cyc)});
        if (sbq.size() > 0 && cyc > sbq[0].due) begin
            total++;
            bad++;
            $display("FAIL timeout: no RDY by cycle %0d want due %0d", cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (bus.data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_rdy: cycle %0d got rdy=1 want 0", cyc);
            end else begin
                e = sbq.pop_front();
                check("rdy_cycle", cyc, e.due);
                check("result", bus.data_result, e.res);
                check("exception", {31'b0, bus.data_exception}, {31'b0, e.exc});
                last_res = e.res;
            end
        end else begin
            check("result_hold", bus.data_result, last_res);
            check("exc_idle", {31'b0, bus.data_exception}, 32'd0);
        end
    end

    task automatic issue(logic [1:0] op, int amt, logic [31:0] a);
        int   c;
        exp_t e;
        @(negedge clock);
        #1;
        bus.ctrl_start    = 1'b1;
        bus.ctrl_op       = op;
        bus.ctrl_shiftamt = 5'(amt);
        bus.data_operandA = a;
        c = cyc;
        if (!model_busy(c)) begin
            e.res = ref_shift(a, op, amt);
            e.exc = (op == 2'b11);
            e.due = c + 1 + (amt + 1) / 2;
            sbq.push_back(e);
            acc_cyc = c;
            acc_lat = 1 + (amt + 1) / 2;
        end
        @(negedge clock);
        #1;
        bus.ctrl_start    = 1'b0;
        bus.ctrl_op       = 2'($urandom);
        bus.ctrl_shiftamt = 5'($urandom);
        bus.data_operandA = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clock);
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results outstanding want 0", sbq.size());
            sbq.delete();
        end
        @(negedge clock);
    endtask

    initial begin
        bus.ctrl_start    = 1'b0;
        bus.ctrl_op       = 2'b00;
        bus.ctrl_shiftamt = '0;
        bus.data_operandA = '0;
        repeat (2) @(negedge clock);
        #2;
        check("rst_result", bus.data_result, 32'd0);
        check("rst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        reset = 1'b1;

        // Abort mid-shift: outputs clear at once and no RDY follows.
        issue(2'b00, 9, 32'h0000_0001);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b0;
        sbq.delete();
        acc_cyc  = -100;
        last_res = '0;
        #1;
        check("abort_result", bus.data_result, 32'd0);
        check("abort_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
        check("abort_exc", {31'b0, bus.data_exception}, 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        @(negedge clock);
        #2;
        reset = 1'b1;

        issue(2'b00, 5, 32'h0000_0001);
        wait_idle();
        issue(2'b10, 31, 32'h8000_0000);
        wait_idle();
        issue(2'b01, 31, 32'h8000_0000);
        wait_idle();
        issue(2'b01, 0, 32'hDEAD_BEEF);
        wait_idle();
        // Second start lands in SHIFT and must be ignored.
        issue(2'b00, 8, 32'h0000_00F1);
        issue(2'b01, 3, 32'hFFFF_0000);
        wait_idle();
        // Second start lands in the DONE cycle of the first.
        issue(2'b00, 2, 32'h0000_0005);
        issue(2'b00, 2, 32'h0000_0003);
        wait_idle();
        issue(2'b11, 1, 32'h0000_0001);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clock);
            issue(2'($urandom), $urandom_range(0, 31), $urandom);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that sequences the fixed shift-by-2 and shift-by-1 stages of the ALU shifter datapath to perform arbitrary-amount SLL/SRL/SRA. Each cycle it applies one fixed stage to an internal working register, so a variable barrel shifter is not needed. It sits between the ALU op decode and the writeback mux, alongside the multdiv unit, and uses the same start/resultRDY handshake style.

Parameters:
WIDTH, 32, datapath width in bits
SHAMT_W, 5, shift-amount width; equals log2(WIDTH)

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
ctrl_start  input  1  one-cycle request to begin a shift
ctrl_op  input  2  00=SLL, 01=SRL, 10=SRA, 11=reserved
ctrl_shiftamt  input  SHAMT_W  shift amount, 0..WIDTH-1
data_operandA  input  WIDTH  value to shift
data_result  output  WIDTH  shifted result; holds until the next completion
data_resultRDY  output  1  one-cycle pulse; data_result is valid
data_exception  output  1  asserted together with data_resultRDY when ctrl_op=11
busy  output  1  high while in SHIFT

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. data_result=0, data_resultRDY=0, data_exception=0, busy=0, working reg=0, count=0, latched op=00. Reset mid-shift aborts the operation and produces no RDY pulse.
- States: IDLE, SHIFT, DONE.
- Accept: ctrl_start is sampled only in IDLE or DONE. On acceptance, the block latches data_operandA into the working reg, ctrl_shiftamt into count, and ctrl_op.
  - Next state is SHIFT if shamt!=0, otherwise DONE.
- Start while in SHIFT (busy=1): ignored. No latch and no queueing.
- SHIFT, per cycle:
  - If count>=2: working reg shifts by 2 and count-=2.
  - If count==1: working reg shifts by 1 and count=0.
  - When count reaches 0 on this edge, the next state is DONE.
- Shift fill rules: SLL fills zeros from bit 0. SRL fills zeros from bit WIDTH-1. SRA replicates the latched sign bit (working reg MSB) into each vacated position.
- Reserved op 11: shifts as SLL, and data_exception=1 in the DONE cycle.
- DONE: data_result is driven from the working reg (registered on entry to DONE), with data_resultRDY=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or a new accept if ctrl_start=1 in that cycle (back-to-back).
- Latency: with start sampled in cycle N, data_resultRDY=1 in cycle N+1+ceil(shamt/2).
  - shamt=0 gives N+1; shamt=31 gives N+17.
- busy is 1 exactly in SHIFT cycles. It is 0 in IDLE and DONE.
- Inputs only need to be stable in the accept cycle; later changes have no effect.
- data_result changes only on entry to DONE; otherwise it holds its previous value.
- count never underflows: the step size is min(count,2).

Test Plan:
- Reset mid-op: start SLL amt=9, deassert-then-assert reset at cycle N+3 -> all outputs 0 immediately, state IDLE, no RDY pulse; a subsequent start behaves normally.
- SLL: operandA=32'h0000_0001, amt=5 -> RDY at N+4, result=32'h0000_0020, busy high for cycles N+1..N+3.
- SRA: operandA=32'h8000_0000, amt=31 -> RDY at N+17, result=32'hFFFF_FFFF. Same input with SRL -> 32'h0000_0001.
- amt=0: operandA=32'hDEAD_BEEF, op SRL -> RDY at N+1, result=32'hDEAD_BEEF, busy never high.
- Back-to-back and ignored starts:
  - ctrl_start during SHIFT is ignored and the result is unchanged.
  - ctrl_start in the DONE cycle (SLL, 32'h3, amt=2) -> second RDY 2 cycles later, result=32'h0000_000C.
- Reserved op=11, operandA=32'h1, amt=1 -> RDY at N+2, result=32'h2, data_exception=1 for that cycle only.
